// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
// Shared types and constants for the instruction fetch stage: reset level,
// bus widths, NOP encoding, fetch FSM state encodings and the packed slot
// type used for both the skid buffer and the IF/ID output register.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam int   INST_ADDR_W = 32;
    localparam int   INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t ZERO_WORD = '0;
    localparam inst_t      NOP_INST  = '0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding
        ST_HOLD  = 2'd1,   // fetched word parked in skid buffer, no request
        ST_DROP  = 2'd2    // request outstanding, its data will be discarded
    } fetch_state_e;

    // One instruction slot: PC, instruction word and a valid flag.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
        logic       valid;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Fetch program counter: loads RESET_PC on reset, takes a word-aligned
// redirect target, otherwise advances by 4 when told to. Wraps silently at
// the top of the address space.
//   clk, rst      : clock, synchronous active-high reset
//   inc_i         : advance PC by 4
//   redirect_i    : load target_i (low two bits forced to zero), wins over inc_i
//   target_i      : redirect address
//   pc_o          : current fetch PC
// ---------------------------------------------------------------------------
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       redirect_i,
    input  inst_addr_t target_i,
    output inst_addr_t pc_o
);

    inst_addr_t pc_d;
    inst_addr_t pc_q;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~inst_addr_t'(3);
        end else if (inc_i) begin
            pc_d = pc_q + inst_addr_t'(4);   // 0xFFFF_FFFC + 4 wraps to 0
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage with a one-entry skid buffer and a registered
// IF/ID output. Zero-wait memory sustains one instruction per cycle.
//   clk, rst                      : clock, synchronous active-high reset
//   stall_i                       : decode cannot accept an instruction
//   branch_flag_i/branch_target_i : redirect from decode (ignored while stalled)
//   imem_req_o/imem_addr_o        : instruction memory read request/address
//   imem_ack_i/imem_data_i        : read data valid / read data
//   pc_o/inst_o/inst_valid_o      : instruction presented to decode
// ---------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    output logic              imem_req_o,
    output logic [31:0]       imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    fetch_state_e state_q, state_d;
    slot_t        out_q, out_d;
    slot_t        skid_q, skid_d;
    inst_addr_t   drop_addr_q, drop_addr_d;
    inst_addr_t   fetch_pc;
    logic         pc_inc;
    logic         ack;
    logic         take_branch;
    slot_t        fetched;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pc_inc),
        .redirect_i (take_branch),
        .target_i   (branch_target_i),
        .pc_o       (fetch_pc)
    );

    // An ack only counts against a live request; this also drops any ack
    // for a request abandoned by reset.
    assign ack         = imem_ack_i && imem_req_o;
    assign take_branch = branch_flag_i && !stall_i;
    assign fetched     = '{pc: fetch_pc, inst: imem_data_i, valid: 1'b1};

    // State register (plus datapath flops).
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_FETCH;
            out_q       <= EMPTY_SLOT;
            skid_q      <= EMPTY_SLOT;
            drop_addr_q <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (take_branch) begin
                    // Without a same-cycle ack the old request is still in flight.
                    state_d = ack ? ST_FETCH : ST_DROP;
                end else if (ack && stall_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:  if (!stall_i) state_d = ST_FETCH;
            ST_DROP:  if (ack)      state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Datapath: IF/ID register, skid buffer, PC control.
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        drop_addr_d = drop_addr_q;
        pc_inc      = 1'b0;
        if (take_branch) begin
            out_d  = EMPTY_SLOT;
            skid_d = EMPTY_SLOT;
            // Keep the address of the request being discarded on the bus.
            if (state_q == ST_FETCH) drop_addr_d = fetch_pc;
        end else if (state_q == ST_FETCH && ack) begin
            pc_inc = 1'b1;
            if (stall_i) skid_d = fetched;
            else         out_d  = fetched;
        end else if (state_q == ST_HOLD && !stall_i) begin
            out_d  = skid_q;
            skid_d = EMPTY_SLOT;
        end else if (!stall_i) begin
            out_d = EMPTY_SLOT;
        end
    end

    // Output logic.
    always_comb begin
        imem_req_o  = (state_q != ST_HOLD) && (rst != RST_ENABLE);
        imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fetch_pc;
    end

    assign pc_o         = out_q.pc;
    assign inst_o       = out_q.inst;
    assign inst_valid_o = out_q.valid;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
REQ-004 stall_i  in  1  decode stage cannot accept a new instruction this cycle.
REQ-005 branch_flag_i  in  1  redirect request from decode.
REQ-006 branch_target_i  in  32  redirect address.
REQ-007 imem_req_o  out  1  instruction memory read request.
REQ-008 imem_addr_o  out  32  word-aligned read address.
REQ-009 imem_ack_i  in  1  read data valid.
REQ-010 imem_data_i  in  32  read data.
REQ-011 pc_o  out  32  PC of the instruction presented to decode.
REQ-012 inst_o  out  32  instruction presented to decode.
REQ-013 inst_valid_o  out  1  pc_o/inst_o hold a real instruction.

Function
REQ-014 Outputs pc_o/inst_o/inst_valid_o SHALL be registered (IF/ID register); inst_o = 32'h0 (NOP) whenever inst_valid_o = 0.
REQ-015 States SHALL be FETCH (request outstanding), HOLD (fetched word parked in skid buffer), DROP (outstanding request whose data is to be discarded).
REQ-016 imem_req_o SHALL be 1 exactly in FETCH and DROP; imem_addr_o SHALL equal the fetch PC and stay stable until imem_ack_i.
REQ-017 imem_ack_i SHALL be ignored when imem_req_o = 0; ack in the same cycle as req is legal (zero-wait memory).
REQ-018 FETCH, ack, stall_i = 0: output register <= {fetch PC, imem_data_i, valid 1}; fetch PC += 4; remain FETCH; throughput 1 instr/cycle with zero-wait memory.
REQ-019 FETCH, ack, stall_i = 1: output register holds; word and its PC SHALL be stored in the skid buffer; fetch PC += 4; go HOLD (no request).
REQ-020 HOLD, stall_i = 0: output register <= skid buffer contents, valid 1; go FETCH.
REQ-021 No ack and stall_i = 0 in FETCH: output register SHALL become a bubble (valid 0, NOP) on next edge.
REQ-022 stall_i = 1 SHALL hold pc_o/inst_o/inst_valid_o unchanged in every state.
REQ-023 branch_flag_i SHALL be honoured only when stall_i = 0; ignored otherwise.
REQ-024 Honoured branch: fetch PC <= {branch_target_i[31:2], 2'b00}; skid buffer cleared; output register <= bubble; same-cycle ack data discarded.
REQ-025 Honoured branch in FETCH without ack: go DROP; in DROP the returning word SHALL be discarded on ack, then go FETCH at the new PC.
REQ-026 Honoured branch in HOLD or with same-cycle ack: go FETCH at target next cycle.
REQ-027 Fetch PC SHALL wrap 32'hFFFF_FFFC + 4 -> 32'h0000_0000 silently.
REQ-028 Every instruction fetched and not flushed SHALL reach inst_o exactly once, in address order.

Reset
REQ-029 While rst = 1 at an edge: fetch PC <= RESET_PC, state <= FETCH, skid buffer cleared, pc_o <= 0, inst_o <= 0, inst_valid_o <= 0.
REQ-030 imem_req_o SHALL be 0 in any cycle where rst = 1; a request outstanding when reset asserts SHALL be abandoned and its ack ignored.
REQ-031 First request SHALL issue in the first cycle with rst = 0, address RESET_PC.

Structure
REQ-032 Shared defines SHALL supply `RstEnable`, `ZeroWord`, `InstAddrBus`, `InstBus`, NOP encoding and state encodings.
REQ-033 The PC counter (reset, +4, wrap, redirect) SHALL be a sub-module named pc_reg; FSM, skid buffer and IF/ID register stay in inst_fetch.

Verification
REQ-034 Reset then zero-wait memory, no stall -> addresses 0x0,0x4,0x8 on consecutive cycles; pc_o 0x0,0x4,0x8 one cycle later, valid 1.
REQ-035 Memory acks 2 cycles after req -> imem_addr_o stable across wait; one bubble per wait cycle on inst_valid_o.
REQ-036 stall_i high 3 cycles while ack returns word for 0x8 -> outputs frozen at 0x4, no request in HOLD; after release pc_o = 0x8 then 0xC, no loss or duplication.
REQ-037 branch_flag_i = 1, target 0x103 while request to 0x10 pending -> 0x10 data discarded, next request address 0x100, bubble in between.
REQ-038 branch with stall_i = 1 -> ignored, PC sequence unchanged.
REQ-039 RESET_PC = 32'hFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; rst mid-wait -> req drops, restarts at RESET_PC.
